jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
Upstream driver for the JK flip-flop stage. It accepts queued commands over a valid/ready handshake: op (hold/reset/set/toggle) plus a repeat length. It drives the flip-flop's J/K inputs for the requested number of clock cycles. It also keeps a registered reference model of the flip-flop's Q (q_exp), so a downstream checker can compare it against the real Q.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
LEN_W, 4, width of cmd_len; drive duration = cmd_len+1 cycles

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; = !rst && (count < DEPTH)
cmd_op  input  2  00 HOLD (J0K0), 01 RESET (J0K1), 10 SET (J1K0), 11 TOGGLE (J1K1)
cmd_len  input  LEN_W  repeat count minus one
j  output  1  registered J to flip-flop
k  output  1  registered K to flip-flop
active  output  1  a command is being driven this cycle
done  output  1  high during the final drive cycle of each command
q_exp  output  1  expected flip-flop Q (reference model)
fifo_count  output  clog2(DEPTH)+1  queued, not-yet-started commands

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: j=0, k=0, active=0, done=0, q_exp=0, fifo_count=0, FSM=IDLE, remaining=0.
- Reset mid-operation flushes all queued commands and the current command; outputs reach their reset values after that edge.
- Push: when cmd_valid && cmd_ready at an edge, {cmd_op, cmd_len} is written to the FIFO tail.
  - When full, cmd_ready=0 and cmd_valid is ignored; the command is not dropped, the source must hold it.
- Pop: occurs at an edge when the FSM needs a command and the FIFO is non-empty.
  - Push and pop at the same edge leave the count unchanged.
  - No bypass: a command pushed into an empty FIFO is popped at the next edge at the earliest.
- FSM IDLE:
  - j=k=0, active=0.
  - If FIFO is non-empty at an edge: pop; register j/k from op, remaining=cmd_len, active=1, done=(cmd_len==0); go to RUN.
- FSM RUN:
  - Each edge with remaining>0: remaining-1; done=(remaining==1).
  - Edge with remaining==0 (final cycle) and FIFO non-empty: pop the next command and load as in IDLE. No gap cycle; done is re-evaluated for the new command.
  - Edge with remaining==0 and FIFO empty: go to IDLE; j=k=0, active=0, done=0.
- Latency and duration:
  - Push at edge t gives first drive cycle after edge t+1, when the FSM was idle and the FIFO empty.
  - Each command drives exactly cmd_len+1 consecutive cycles; done is high only in the last of them.
- q_exp: on every edge not in reset, update from the current registered j/k:
  - 00 hold
  - 01 -> 0
  - 10 -> 1
  - 11 -> invert
  - It matches the flip-flop's Q at the same clk, provided the flip-flop starts at Q=0.
- Arithmetic: remaining is LEN_W bits and never underflows. cmd_len = 2^LEN_W-1 gives 2^LEN_W cycles.
- FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count saturation is prevented by cmd_ready.

Decomposition:
- Shared header jk_defs.vh:
  - op encodings OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE
  - FSM state encodings S_IDLE, S_RUN
  - shared by the sequencer, bench and future checker
- One sub-module: jk_cmd_fifo. Synchronous FIFO with parameters DEPTH and WIDTH (=2+LEN_W).
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - rd_data is combinational from the head entry.
- The top holds the FSM, the remaining counter, j/k/done registers and the q_exp model.

Test Plan:
- Reset held 3 cycles with cmd_valid=1 -> cmd_ready=0; j=k=0, q_exp=0, fifo_count=0 throughout; nothing is queued.
- Push SET len=2 at edge t -> j=1,k=0,active=1 after edges t+1..t+3; done only after t+3; q_exp=1 from t+2 on; idle with j=k=0 after t+4.
- Push TOGGLE len=3, then RESET len=0 back-to-back:
  - q_exp toggles 4 times (0,1,0,1,0 sequence);
  - RESET drives the cycle immediately after the TOGGLE done cycle with no gap;
  - done high twice; q_exp=0 at end.
- Push 6 commands, each len=15, with cmd_valid held -> fifo_count peaks at 4 and cmd_ready=0 while full; the stalled commands enter in order as slots free; all 6 executed in order, total 96 drive cycles.
- Assert rst mid-RUN with 2 commands queued -> after that edge j=k=0, active=0, fifo_count=0, q_exp=0; the queued commands are never driven.
- Connect to the JK flip-flop instance on the same clk, then run random ops and lengths for 500 cycles -> Q==q_exp on every cycle.

Source files
------------

// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared encodings for the JK command sequencer: command opcodes and FSM states.
// Imported by the sequencer, its bench and any downstream Q checker.
package jk_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with a combinational head read-out.
// Writes while full and reads while empty are ignored.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives a JK flip-flop from queued (op, len) commands and keeps a registered
// reference model of the flip-flop's Q for a downstream checker.
module jk_cmd_sequencer
    import jk_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     j,
    output logic                     k,
    output logic                     active,
    output logic                     done,
    output logic                     q_exp,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int WIDTH = 2 + LEN_W;

    state_e           state;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] head;
    logic [1:0]       head_op;
    logic [LEN_W-1:0] head_len;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign cmd_ready = !rst && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign head_op   = head[WIDTH-1:LEN_W];
    assign head_len  = head[LEN_W-1:0];

    // A new command is taken when idle or on the final cycle of the current one.
    assign pop = !fifo_empty && ((state == S_IDLE) || (remaining == '0));

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({cmd_op, cmd_len}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            active    <= 1'b0;
            done      <= 1'b0;
            q_exp     <= 1'b0;
        end else begin
            // The model follows the j/k the flip-flop sees at this same edge.
            case ({j, k})
                2'b01:   q_exp <= 1'b0;
                2'b10:   q_exp <= 1'b1;
                2'b11:   q_exp <= ~q_exp;
                default: q_exp <= q_exp;
            endcase

            if (pop) begin
                state     <= S_RUN;
                remaining <= head_len;
                j         <= head_op[1];
                k         <= head_op[0];
                active    <= 1'b1;
                done      <= (head_len == '0);
            end else if (state == S_RUN) begin
                if (remaining != '0) begin
                    remaining <= remaining - 1'b1;
                    done      <= (remaining == LEN_W'(1));
                end else begin
                    state  <= S_IDLE;
                    j      <= 1'b0;
                    k      <= 1'b0;
                    active <= 1'b0;
                    done   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer plus a random run against a JK flip-flop
// model clocked alongside it.
module tb_jk_cmd_sequencer;
    import jk_cmd_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             j;
    logic             k;
    logic             active;
    logic             done;
    logic             q_exp;
    logic [2:0]       fifo_count;

    logic             ff_q;
    int               vectors = 0;
    int               miscompares = 0;

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .j          (j),
        .k          (k),
        .active     (active),
        .done       (done),
        .q_exp      (q_exp),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the real JK flip-flop stage, starting from Q=0.
    always @(posedge clk) begin
        if (rst) begin
            ff_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [LEN_W-1:0] len);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_len   = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Bundle order: cmd_ready, j, k, active, done, q_exp, fifo_count.
    task automatic checkAll(input string tag, input logic r, input logic jj, input logic kk,
                            input logic a, input logic d, input logic q, input logic [2:0] cnt);
        checkOutput(tag, 32'({cmd_ready, j, k, active, done, q_exp, fifo_count}),
                    32'({r, jj, kk, a, d, q, cnt}));
    endtask

    initial begin
        logic [1:0] ops [6];
        int         idx;
        int         drive_cycles;
        int         done_pulses;
        int         waited;
        logic       accepted;

        rst = 1'b1;
        applyStimulus(1'b1, OP_SET, 4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("reset_hold", 0, 0, 0, 0, 0, 0, 3'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, OP_HOLD, 4'd0);
        tick();
        checkAll("post_reset_idle", 1, 0, 0, 0, 0, 0, 3'd0);

        // SET len=2: three drive cycles, done on the last.
        applyStimulus(1'b1, OP_SET, 4'd2);
        tick();
        checkAll("set_pushed", 1, 0, 0, 0, 0, 0, 3'd1);
        applyStimulus(1'b0, OP_HOLD, 4'd0);
        tick();
        checkAll("set_cycle1", 1, 1, 0, 1, 0, 0, 3'd0);
        tick();
        checkAll("set_cycle2", 1, 1, 0, 1, 0, 1, 3'd0);
        tick();
        checkAll("set_cycle3_done", 1, 1, 0, 1, 1, 1, 3'd0);
        tick();
        checkAll("set_idle", 1, 0, 0, 0, 0, 1, 3'd0);

        rst = 1'b1;
        tick();
        checkAll("idle_reset", 0, 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;

        // TOGGLE len=3 then RESET len=0 with no gap between them.
        applyStimulus(1'b1, OP_TOGGLE, 4'd3);
        tick();
        checkAll("tog_pushed", 1, 0, 0, 0, 0, 0, 3'd1);
        applyStimulus(1'b1, OP_RESET, 4'd0);
        tick();
        checkAll("tog_cycle1", 1, 1, 1, 1, 0, 0, 3'd1);
        applyStimulus(1'b0, OP_HOLD, 4'd0);
        tick();
        checkAll("tog_cycle2", 1, 1, 1, 1, 0, 1, 3'd1);
        tick();
        checkAll("tog_cycle3", 1, 1, 1, 1, 0, 0, 3'd1);
        tick();
        checkAll("tog_cycle4_done", 1, 1, 1, 1, 1, 1, 3'd1);
        tick();
        checkAll("rstcmd_done", 1, 0, 1, 1, 1, 0, 3'd0);
        tick();
        checkAll("tog_idle", 1, 0, 0, 0, 0, 0, 3'd0);

        // Six len=15 commands with cmd_valid held through the full stall.
        ops          = '{OP_SET, OP_TOGGLE, OP_RESET, OP_TOGGLE, OP_SET, OP_HOLD};
        idx          = 0;
        drive_cycles = 0;
        done_pulses  = 0;
        for (int n = 1; n <= 100; n++) begin
            if (idx < 6) begin
                applyStimulus(1'b1, ops[idx], 4'd15);
            end else begin
                applyStimulus(1'b0, OP_HOLD, 4'd0);
            end
            accepted = cmd_valid && cmd_ready;
            tick();
            if (accepted) begin
                idx++;
            end
            if (active) begin
                drive_cycles++;
            end
            if (done) begin
                done_pulses++;
            end
            case (n)
                5:  checkAll("burst_full", 0, 1, 0, 1, 0, 1, 3'd4);
                17: checkAll("c0_last", 0, 1, 0, 1, 1, 1, 3'd4);
                18: checkAll("c1_first", 1, 1, 1, 1, 0, 1, 3'd3);
                19: checkAll("c5_enters", 0, 1, 1, 1, 0, 0, 3'd4);
                34: checkAll("c2_first", 1, 0, 1, 1, 0, 1, 3'd3);
                50: checkAll("c3_first", 1, 1, 1, 1, 0, 0, 3'd2);
                66: checkAll("c4_first", 1, 1, 0, 1, 0, 0, 3'd1);
                82: checkAll("c5_first", 1, 0, 0, 1, 0, 1, 3'd0);
                97: checkAll("c5_last", 1, 0, 0, 1, 1, 1, 3'd0);
                98: checkAll("burst_idle", 1, 0, 0, 0, 0, 1, 3'd0);
                default: ;
            endcase
        end
        checkOutput("burst_drive_cycles", 32'(drive_cycles), 32'd96);
        checkOutput("burst_done_pulses", 32'(done_pulses), 32'd6);
        checkOutput("burst_accepted", 32'(idx), 32'd6);

        // Reset while running with two commands still queued.
        applyStimulus(1'b1, OP_TOGGLE, 4'd7);
        tick();
        applyStimulus(1'b1, OP_SET, 4'd3);
        tick();
        applyStimulus(1'b1, OP_SET, 4'd3);
        tick();
        applyStimulus(1'b0, OP_HOLD, 4'd0);
        tick();
        checkAll("pre_flush_run", 1, 1, 1, 1, 0, 1, 3'd2);
        rst = 1'b1;
        tick();
        checkAll("flush", 0, 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkAll("flush_idle", 1, 0, 0, 0, 0, 0, 3'd0);
        end

        // Random traffic: the flip-flop's Q must track q_exp every cycle.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          LEN_W'($urandom_range(0, 3)));
            tick();
            checkOutput("ff_q_vs_q_exp", 32'(q_exp), 32'(ff_q));
        end
        applyStimulus(1'b0, OP_HOLD, 4'd0);
        waited = 0;
        while ((active || fifo_count != 3'd0) && waited < 400) begin
            tick();
            waited++;
        end
        checkOutput("drain_idle", 32'(!active && fifo_count == 3'd0), 32'd1);
        checkOutput("drain_q", 32'(q_exp), 32'(ff_q));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
